// File: rtl/cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_ctrl_pkg
//  Purpose  : Shared types and widths for the data-cache front-end controller.
//  Revision : 1.0 - initial release
// ============================================================================
package cache_ctrl_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    FILL    = 2'd2,
    WR      = 2'd3
  } state_e;

  // Default data-memory base address; cache/SRAM offset = addr - base
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

  // Cache address: tag 10 | index 6 | word 1 | byte 2
  localparam int CADDR_W = 19;
  localparam int LINE_W  = 64;
  localparam int WORD_W  = 32;

endpackage
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
//  Module   : cache_controller
//  Purpose  : MEM-stage front end for the 2-way data cache. Zero-latency read
//             hits, 64-bit line fetch + fill on read miss, write-through /
//             no-allocate stores that invalidate the cached copy.
//  Options  : CACHE_CTRL_PERF_CNT_EN - adds saturating hit_cnt / miss_cnt.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_controller
  import cache_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         mem_addr,
  input  logic [WORD_W-1:0]   mem_wdata,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  output logic [WORD_W-1:0]   mem_rdata,
  output logic                ready,
  output logic [CADDR_W-1:0]  cache_addr,
  output logic                cache_r_en,
  output logic                cache_w_en,
  output logic                cache_invalidate,
  output logic [LINE_W-1:0]   cache_wdata,
  input  logic                cache_hit,
  input  logic [WORD_W-1:0]   cache_rdata,
  output logic [31:0]         sram_addr,
  output logic [WORD_W-1:0]   sram_wdata,
  output logic                sram_r_en,
  output logic                sram_w_en,
  input  logic [LINE_W-1:0]   sram_rdata,
  input  logic                sram_ready
`ifdef CACHE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
`endif
);

  state_e              r_state;
  state_e              w_next;
  logic [31:0]         r_off;
  logic [WORD_W-1:0]   r_wdata;
  logic [LINE_W-1:0]   r_line;

  logic [31:0]         w_off;
  logic                w_idle_wr;
  logic                w_idle_hit;
  logic                w_idle_miss;

  // Offset into data memory (wraps for addresses below the base)
  assign w_off       = mem_addr - BASE_ADDR;
  assign w_idle_wr   = (r_state == IDLE) && mem_w_en;
  assign w_idle_hit  = (r_state == IDLE) && !mem_w_en && mem_r_en && cache_hit;
  assign w_idle_miss = (r_state == IDLE) && !mem_w_en && mem_r_en && !cache_hit;

  // State and request capture registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_off   <= '0;
      r_wdata <= '0;
      r_line  <= '0;
    end else begin
      r_state <= w_next;
      if (w_idle_wr) begin
        r_off   <= w_off;
        r_wdata <= mem_wdata;
      end else if (w_idle_miss) begin
        r_off   <= w_off;
      end
      if (r_state == RD_MISS && sram_ready) begin
        r_line <= sram_rdata;
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    w_next           = r_state;
    ready            = 1'b1;
    mem_rdata        = '0;
    cache_addr       = r_off[CADDR_W-1:0];
    cache_r_en       = 1'b0;
    cache_w_en       = 1'b0;
    cache_invalidate = 1'b0;
    cache_wdata      = '0;
    sram_addr        = '0;
    sram_wdata       = '0;
    sram_r_en        = 1'b0;
    sram_w_en        = 1'b0;
    case (r_state)
      IDLE: begin
        cache_addr = w_off[CADDR_W-1:0];
        if (mem_w_en) begin
          cache_invalidate = 1'b1;
          ready            = 1'b0;
          w_next           = WR;
        end else if (mem_r_en) begin
          if (cache_hit) begin
            cache_r_en = 1'b1;
            mem_rdata  = cache_rdata;
          end else begin
            ready  = 1'b0;
            w_next = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        ready     = 1'b0;
        sram_r_en = 1'b1;
        sram_addr = {r_off[31:3], 3'b000};
        if (sram_ready) w_next = FILL;
      end
      FILL: begin
        cache_w_en  = 1'b1;
        cache_wdata = r_line;
        mem_rdata   = r_off[2] ? r_line[63:32] : r_line[31:0];
        w_next      = IDLE;
      end
      WR: begin
        sram_w_en  = 1'b1;
        sram_addr  = r_off;
        sram_wdata = r_wdata;
        ready      = sram_ready;
        if (sram_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef CACHE_CTRL_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Saturating hit / miss event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_idle_hit && r_hit_cnt != 32'hFFFF_FFFF)   r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_idle_miss && r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  // Hit indication only feeds the optional counters
  logic w_unused;
  assign w_unused = w_idle_hit;
`endif

endmodule
`default_nettype wire
